uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
// Shares one uart_tx transmitter between N_REQ byte requesters in impl_top (for example,
// an echo path, a status reporter and a debug dump). It picks a requester round-robin and
// launches one byte into the transmitter. It then tracks the transmitter's busy flag until
// the frame is complete. An optional per-requester lock lets one requester send a
// contiguous burst of up to MAX_BURST bytes.
//
// PARAMETERS
// N_REQ          4      number of requesters, 2..8
// MAX_BURST      16     max consecutive locked grants to one requester, >=1
// START_TIMEOUT  8      cycles to wait for uart_tx_busy to rise after uart_tx_en, >=2
//
// PORTS
// clk           in   1          system clock
// resetn        in   1          asynchronous active-low reset
// req_valid     in   N_REQ      requester i has a byte pending
// req_data      in   8*N_REQ    byte i = req_data[8*i+7:8*i]
// req_lock      in   N_REQ      keep grant after this byte (burst)
// req_ready     out  N_REQ      one-cycle accept strobe, one-hot
// grant_id      out  3          index of the last accepted requester
// uart_tx_en    out  1          one-cycle launch strobe to uart_tx
// uart_tx_data  out  8          byte to uart_tx, held stable until the frame ends
// uart_tx_busy  in   1          uart_tx frame in progress
// arb_busy      out  1          high in every state except IDLE
// err_timeout   out  1          one-cycle pulse: busy never rose after a launch
//
// BEHAVIOUR
// Reset (async, resetn=0):
// - All outputs are 0; state=IDLE; rr_ptr=0; burst_cnt=0; lock_hold=0.
// - Reset mid-frame aborts tracking immediately. The transmitter is not stopped.
//
// States: IDLE, SEND, WAIT_START, WAIT_DONE.
// - IDLE, when |req_valid and uart_tx_busy=0, at the clock edge:
//   - latch the winner's byte into uart_tx_data;
//   - set uart_tx_en=1, req_ready[w]=1 and grant_id=w;
//   - go to SEND.
// - IDLE with uart_tx_busy=1 (external use) waits.
// - SEND lasts exactly 1 cycle: uart_tx_en and req_ready drop, then go to WAIT_START.
// - WAIT_START:
//   - uart_tx_busy=1 -> WAIT_DONE.
//   - After START_TIMEOUT cycles without busy: pulse err_timeout for 1 cycle, go to IDLE.
// - WAIT_DONE: uart_tx_busy=0 -> IDLE. The next arbitration happens in IDLE on the
//   following edge.
// - Latency from req_valid (arbiter in IDLE) to uart_tx_en: 1 edge. Minimum spacing
//   between launches is frame time + 2 cycles.
//
// Handshake:
// - Requester i holds req_valid[i] and its data stable until it sees req_ready[i]=1.
// - The transfer completes in the cycle req_ready[i]=1. The requester may present its
//   next byte from the following cycle.
// - Dropping req_valid before ready is permitted. That byte is simply not sent.
//
// Arbitration, evaluated in IDLE only:
// - Lock rule: if lock_hold=1, req_valid[grant_id]=1 and burst_cnt<MAX_BURST, the winner
//   is grant_id.
// - Otherwise the winner is the first i with req_valid[i]=1, scanning
//   rr_ptr, rr_ptr+1, ... modulo N_REQ.
// - On accept:
//   - rr_ptr = (w+1) mod N_REQ;
//   - lock_hold = req_lock[w];
//   - burst_cnt = burst_cnt+1 if w repeats a locked grant, else 1.
// - Lock is broken if the holder drops req_valid while in IDLE. Another requester then
//   wins and burst_cnt restarts.
// - At burst_cnt=MAX_BURST the lock is ignored. If the holder is the only valid
//   requester it still wins, with burst_cnt=1.
// - Width rule: grant_id is zero-extended to 3 bits. burst_cnt is $clog2(MAX_BURST+1)
//   bits and saturates.
//
// TESTING
// 1. Reset: resetn=0 mid-WAIT_DONE -> all outputs 0 immediately; after release, IDLE
//    and no uart_tx_en.
// 2. Single req: req_valid=4'b0100, byte 0xA5 -> uart_tx_en and req_ready=4'b0100 one
//    cycle after; uart_tx_data=0xA5; grant_id=2.
// 3. Round-robin: all four valid, no lock, 8 bytes -> grant order 0,1,2,3,0,1,2,3.
// 4. Burst: req 1 with lock=1 and 20 bytes queued, req 3 valid -> 16 grants to 1, then 3,
//    then 1 again.
// 5. Timeout: model uart_tx_busy stuck at 0, START_TIMEOUT=8 -> err_timeout pulses
//    9 cycles after uart_tx_en; back to IDLE.
// 6. Busy external: uart_tx_busy=1 in IDLE with req_valid -> no launch until busy=0,
//    then launch on the next edge.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals shared by uart_tx_arbiter and its environment.
// master = requesters plus the uart_tx model; slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   req_ready;
    logic [2:0]         grant_id;
    logic               uart_tx_en;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_busy;

    modport master (
        output req_valid, req_data, req_lock, uart_tx_busy,
        input  req_ready, grant_id, uart_tx_en, uart_tx_data
    );

    modport slave (
        input  req_valid, req_data, req_lock, uart_tx_busy,
        output req_ready, grant_id, uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters, with an
// optional per-requester lock for contiguous bursts of up to MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             resetn,
    uart_tx_arbiter_if.slave bus,
    output logic             arb_busy,
    output logic             err_timeout
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int TMR_W = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] held_id;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] burst_cnt;
    logic [TMR_W-1:0] start_tmr;
    logic             lock_hold;
    logic             use_lock;
    logic             win_found;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDX_W'(sum);
    endfunction

    // Lock wins while the holder still has data and its burst is not exhausted;
    // otherwise scan from rr_ptr, keeping the lowest offset that is valid.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        win_idx   = '0;
        win_found = 1'b0;
        use_lock  = lock_hold && bus.req_valid[held_id] && (burst_cnt < CNT_W'(MAX_BURST));
        if (use_lock) begin
            win_idx   = held_id;
            win_found = 1'b1;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[wrap_add(rr_ptr, k)]) begin
                    win_idx   = wrap_add(rr_ptr, k);
                    win_found = 1'b1;
                end
            end
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            held_id          <= '0;
            burst_cnt        <= '0;
            lock_hold        <= 1'b0;
            start_tmr        <= '0;
            bus.req_ready    <= '0;
            bus.grant_id     <= '0;
            bus.uart_tx_en   <= 1'b0;
            bus.uart_tx_data <= '0;
            arb_busy         <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            bus.uart_tx_en <= 1'b0;
            bus.req_ready  <= '0;
            err_timeout    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_found && !bus.uart_tx_busy) begin
                        bus.uart_tx_data <= bus.req_data[8*win_idx +: 8];
                        bus.uart_tx_en   <= 1'b1;
                        bus.req_ready    <= N_REQ'(1) << win_idx;
                        bus.grant_id     <= 3'(win_idx);
                        held_id          <= win_idx;
                        rr_ptr           <= wrap_add(win_idx, 1);
                        lock_hold        <= bus.req_lock[win_idx];
                        burst_cnt        <= use_lock ? burst_cnt + 1'b1 : CNT_W'(1);
                        arb_busy         <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    start_tmr <= '0;
                    state     <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (start_tmr == TMR_W'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        arb_busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        start_tmr <= start_tmr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_tx_busy) begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester queues, a uart_tx busy model,
// and a monitor that checks every launch against hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int N_REQ = 4;
    localparam int FRAME = 10;

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic arb_busy;
    logic err_timeout;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .MAX_BURST(16), .START_TIMEOUT(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] req_q[N_REQ][$];
    logic [N_REQ-1:0] lock_cfg = '0;
    logic       uart_dead = 1'b0;
    logic       ext_busy  = 1'b0;
    int         frame_cnt = 0;
    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requesters: present the head of each queue, pop it on req_ready.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_lock  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
                bus.req_valid[i] = (req_q[i].size() > 0);
                if (req_q[i].size() > 0) bus.req_data[8*i +: 8] = req_q[i][0];
                else                     bus.req_data[8*i +: 8] = 8'h00;
                bus.req_lock[i] = lock_cfg[i];
            end
        end
    end

    // uart_tx model: busy for FRAME cycles after each launch; not affected by arbiter reset.
    initial begin
        bus.uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (frame_cnt > 0) frame_cnt--;
            if (bus.uart_tx_en && !uart_dead) frame_cnt = FRAME;
            bus.uart_tx_busy = (frame_cnt != 0) || ext_busy;
        end
    end

    // Monitor: each launch pops one expectation; data must hold while the arbiter is busy.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.uart_tx_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 32'(bus.grant_id), 32'hFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("launch_grant", 32'(bus.grant_id), 32'(e.id));
                    check("launch_data", 32'(bus.uart_tx_data), 32'(e.data));
                    check("launch_ready", 32'(bus.req_ready), 32'(4'b0001 << e.id));
                end
                last_data = bus.uart_tx_data;
            end else if (resetn && arb_busy) begin
                check("data_hold", 32'(bus.uart_tx_data), 32'(last_data));
            end
        end
    end

    task automatic expect_launch(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 3'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, 32'(bus.uart_tx_en), 0);
        check({tag, "_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_grant"}, 32'(bus.grant_id), 0);
        check({tag, "_data"}, 32'(bus.uart_tx_data), 0);
        check({tag, "_arb_busy"}, 32'(arb_busy), 0);
        check({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_q[i].delete();
        exp_q.delete();
        lock_cfg = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Counts negedges until uart_tx_en is seen; an expired bound is a failed comparison.
    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.uart_tx_en && n < 60);
        if (!bus.uart_tx_en) check("launch_wait_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        int pend;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            pend = exp_q.size();
            for (int i = 0; i < N_REQ; i++) pend += req_q[i].size();
        end while ((pend != 0 || arb_busy || bus.uart_tx_busy) && n < 2000);
        check("drain_pending", 32'(pend), 0);
    endtask

    initial begin
        int n;
        int k;
        int en_seen;

        // Reset state
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset mid-WAIT_DONE: outputs clear at once, no relaunch afterwards
        req_q[0].push_back(8'h3C);
        expect_launch(0, 8'h3C);
        wait_en(n);
        repeat (4) @(negedge clk);
        check("pre_reset_arb_busy", 32'(arb_busy), 1);
        #1 resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        resetn  = 1'b1;
        en_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.uart_tx_en) en_seen++;
        end
        check("post_reset_no_launch", 32'(en_seen), 0);
        check("post_reset_idle", 32'(arb_busy), 0);
        drain();

        // Single request on requester 2
        do_reset();
        req_q[2].push_back(8'hA5);
        expect_launch(2, 8'hA5);
        k = 0;
        while (!bus.req_valid[2] && k < 5) begin
            @(negedge clk);
            k++;
        end
        wait_en(n);
        check("single_latency", 32'(n), 1);
        check("single_ready", 32'(bus.req_ready), 32'(4'b0100));
        check("single_grant", 32'(bus.grant_id), 2);
        check("single_data", 32'(bus.uart_tx_data), 32'h A5);
        @(negedge clk);
        check("single_en_pulse", 32'(bus.uart_tx_en), 0);
        check("single_ready_pulse", 32'(bus.req_ready), 0);
        drain();

        // Round-robin across four requesters, two bytes each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) begin
                req_q[i].push_back(8'(8'h10 + 16 * i + r));
                expect_launch(i, 8'(8'h10 + 16 * i + r));
            end
        drain();

        // Burst: requester 1 locked with 20 bytes, requester 3 waiting
        do_reset();
        lock_cfg = 4'b0010;
        for (int b = 0; b < 20; b++) req_q[1].push_back(8'(8'h40 + b));
        req_q[3].push_back(8'hEE);
        for (int b = 0; b < 16; b++) expect_launch(1, 8'(8'h40 + b));
        expect_launch(3, 8'hEE);
        for (int b = 16; b < 20; b++) expect_launch(1, 8'(8'h40 + b));
        drain();

        // Start timeout: transmitter never raises busy
        do_reset();
        uart_dead = 1'b1;
        req_q[0].push_back(8'h77);
        expect_launch(0, 8'h77);
        wait_en(n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!err_timeout && k < 20);
        check("timeout_latency", 32'(k), 9);
        check("timeout_idle", 32'(arb_busy), 0);
        @(negedge clk);
        check("timeout_pulse", 32'(err_timeout), 0);
        uart_dead = 1'b0;
        drain();

        // External busy holds off the launch until it drops
        do_reset();
        ext_busy = 1'b1;
        repeat (2) @(negedge clk);
        req_q[1].push_back(8'h5A);
        expect_launch(1, 8'h5A);
        en_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.uart_tx_en) en_seen++;
        end
        check("ext_busy_hold", 32'(en_seen), 0);
        check("ext_busy_idle", 32'(arb_busy), 0);
        ext_busy = 1'b0;
        k = 0;
        while (bus.uart_tx_busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("ext_busy_release", 32'(bus.uart_tx_en), 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors", errors);
        $fatal(1, "watchdog");
    end
endmodule
